// File: rtl/phy_rx_pkg.sv
// Shared constants and FSM encoding for the serial RX alignment path.
package phy_rx_pkg;

  localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } rx_state_e;

endpackage

// File: rtl/phy_rx_sync_ctrl_if.sv
// Serial-in / aligned-byte-out bundle between a bit source and the sync controller.
interface phy_rx_sync_ctrl_if;

  logic       sync_en;
  logic       data_in;
  logic [7:0] byte_out;
  logic       byte_strobe;
  logic       valid_out;
  logic       locked;
  logic       lock_lost;
  logic [1:0] state;

  modport master (
    output sync_en, data_in,
    input  byte_out, byte_strobe, valid_out, locked, lock_lost, state
  );

  modport slave (
    input  sync_en, data_in,
    output byte_out, byte_strobe, valid_out, locked, lock_lost, state
  );

endinterface

// File: rtl/phy_rx_comma_det.sv
// 8-bit MSB-first deserialiser with a comma comparator on the current window.
module phy_rx_comma_det
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COMMA = COMMA_DEFAULT
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] shift_q,
  output logic       comma_hit
);

  logic [7:0] shift_d;

  always_comb shift_d = {shift_q[6:0], data_in};

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) shift_q <= '0;
    else        shift_q <= shift_d;
  end

  assign comma_hit = (shift_q == COMMA);

endmodule

// File: rtl/phy_rx_sync_ctrl.sv
// Comma-based byte alignment: hunts for a comma, confirms it on aligned boundaries,
// then emits aligned bytes until too long a comma-free run or sync_en drops.
module phy_rx_sync_ctrl
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COMMA        = COMMA_DEFAULT,
  parameter int         LOCK_COUNT   = 4,
  parameter int         MAX_DATA_RUN = 64
) (
  input  logic           clk_8f,
  input  logic           reset,
  phy_rx_sync_ctrl_if.slave rx
);

  localparam int               RUN_W    = $clog2(MAX_DATA_RUN + 1);
  localparam logic [2:0]       LOCK_CNT = 3'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_DATA_RUN);

  logic [7:0] shift_q;
  logic       comma_hit;

  phy_rx_comma_det #(.COMMA(COMMA)) u_comma_det (
    .clk_8f    (clk_8f),
    .reset     (reset),
    .data_in   (rx.data_in),
    .shift_q   (shift_q),
    .comma_hit (comma_hit)
  );

  rx_state_e        state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [2:0]       comma_cnt_q, comma_cnt_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [7:0]       byte_out_q, byte_out_d;
  logic             byte_strobe_q, byte_strobe_d;
  logic             valid_out_q, valid_out_d;
  logic             locked_q, locked_d;
  logic             lock_lost_q, lock_lost_d;

  logic             boundary;
  logic [2:0]       comma_next;
  logic [RUN_W-1:0] run_next;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q + 3'd1;
    comma_cnt_d   = comma_cnt_q;
    run_cnt_d     = run_cnt_q;
    byte_out_d    = byte_out_q;
    byte_strobe_d = 1'b0;
    valid_out_d   = 1'b0;
    lock_lost_d   = 1'b0;
    boundary      = (bit_cnt_q == 3'd7);
    comma_next    = comma_cnt_q + 3'd1;
    run_next      = (run_cnt_q == RUN_MAX) ? run_cnt_q : run_cnt_q + RUN_W'(1);

    if (!rx.sync_en) begin
      state_d     = HUNT;
      bit_cnt_d   = '0;
      comma_cnt_d = '0;
      run_cnt_d   = '0;
      lock_lost_d = (state_q == LOCKED);
    end else begin
      case (state_q)
        CHECK: begin
          if (boundary) begin
            if (comma_hit) begin
              comma_cnt_d = comma_next;
              if (comma_next >= LOCK_CNT) begin
                state_d   = LOCKED;
                run_cnt_d = '0;
              end
            end else begin
              state_d     = HUNT;
              bit_cnt_d   = '0;
              comma_cnt_d = '0;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            byte_out_d    = shift_q;
            byte_strobe_d = 1'b1;
            valid_out_d   = !comma_hit;
            if (comma_hit) begin
              run_cnt_d = '0;
            end else begin
              run_cnt_d = run_next;
              if (run_next == RUN_MAX) begin
                state_d     = HUNT;
                lock_lost_d = 1'b1;
                bit_cnt_d   = '0;
                comma_cnt_d = '0;
                run_cnt_d   = '0;
              end
            end
          end
        end
        default: begin
          // HUNT, and the unused encoding 2'd3 which behaves identically.
          state_d     = HUNT;
          bit_cnt_d   = '0;
          comma_cnt_d = '0;
          run_cnt_d   = '0;
          if (comma_hit) begin
            state_d     = CHECK;
            comma_cnt_d = 3'd1;
          end
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state_q       <= HUNT;
      bit_cnt_q     <= '0;
      comma_cnt_q   <= '0;
      run_cnt_q     <= '0;
      byte_out_q    <= '0;
      byte_strobe_q <= 1'b0;
      valid_out_q   <= 1'b0;
      locked_q      <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      comma_cnt_q   <= comma_cnt_d;
      run_cnt_q     <= run_cnt_d;
      byte_out_q    <= byte_out_d;
      byte_strobe_q <= byte_strobe_d;
      valid_out_q   <= valid_out_d;
      locked_q      <= locked_d;
      lock_lost_q   <= lock_lost_d;
    end
  end

  assign rx.byte_out    = byte_out_q;
  assign rx.byte_strobe = byte_strobe_q;
  assign rx.valid_out   = valid_out_q;
  assign rx.locked      = locked_q;
  assign rx.lock_lost   = lock_lost_q;
  assign rx.state       = state_q;

endmodule

// File: doc/phy_rx_sync_ctrl.md
PHY_RX_SYNC_CTRL -- requirements
Module: phy_rx_sync_ctrl

Interface
REQ-001 Parameters SHALL be: COMMA, default 8'hBC, the idle/alignment byte; LOCK_COUNT, default 4, the number of aligned commas needed for lock (range 1..7); MAX_DATA_RUN, default 64, the number of consecutive non-comma bytes that drops lock.
REQ-002 Ports SHALL be as follows; the block has one clock, and reset is asynchronous and active-low.
- clk_8f  in  1  bit-rate clock.
- reset  in  1  async active-low reset.
- sync_en  in  1  enables hunting and tracking; low forces HUNT.
- data_in  in  1  serial bit, MSB first.
- byte_out  out  8  aligned byte.
- byte_strobe  out  1  one-cycle pulse per aligned byte while LOCKED.
- valid_out  out  1  byte_out is payload (non-comma).
- locked  out  1  high in LOCKED.
- lock_lost  out  1  one-cycle pulse on a LOCKED-to-HUNT transition.
- state  out  2  current FSM state encoding.

Function
REQ-003 The block SHALL shift each clk_8f cycle: shift_q <= {shift_q[6:0], data_in}.
REQ-004 The FSM SHALL have three states: HUNT=2'd0, CHECK=2'd1, LOCKED=2'd2; 2'd3 SHALL be unreachable and decode to HUNT.
REQ-005 In HUNT, shift_q==COMMA in cycle t SHALL give the following at t+1: state=CHECK, bit_cnt=0, comma_cnt=1.
REQ-006 In CHECK/LOCKED, bit_cnt SHALL increment modulo 8 every cycle. A boundary cycle is one with bit_cnt==7, when shift_q holds the next aligned byte.
REQ-007 In CHECK at a boundary, a shift_q==COMMA SHALL increment comma_cnt. When the new count equals LOCK_COUNT, the next state SHALL be LOCKED and run_cnt SHALL clear.
REQ-008 In CHECK at a boundary, a shift_q!=COMMA SHALL return the block to HUNT with comma_cnt=0 and no lock_lost pulse.
REQ-009 In CHECK and LOCKED, comma patterns at non-boundary cycles SHALL be ignored (no realignment).
REQ-010 In LOCKED at each boundary, the cycle after SHALL show: byte_out=shift_q, byte_strobe=1, and valid_out=(shift_q!=COMMA).
- byte_strobe and valid_out are low on all other cycles.
- byte_out holds its value between strobes.
REQ-011 In LOCKED, a comma byte SHALL clear run_cnt and a non-comma byte SHALL increment it. When run_cnt reaches MAX_DATA_RUN:
- next state HUNT, lock_lost=1 for one cycle;
- that final byte is still emitted per REQ-010.
REQ-012 locked SHALL be registered and equal (state==LOCKED).
REQ-013 run_cnt SHALL be $clog2(MAX_DATA_RUN+1) bits and saturating; comma_cnt SHALL be 3 bits.
REQ-014 sync_en low SHALL force the following at the next edge, overriding every other event:
- state HUNT, counters 0, byte_strobe/valid_out 0;
- lock_lost pulses if the block was LOCKED;
- byte_out holds.
REQ-015 Latency from the last bit of a byte (data_in sampled) to byte_strobe SHALL be 2 cycles: shift, boundary, output.

Reset
REQ-016 reset low SHALL asynchronously clear the following:
- shift_q=0, bit_cnt=0, comma_cnt=0, run_cnt=0, state=HUNT;
- byte_out=0, byte_strobe=0, valid_out=0, locked=0, lock_lost=0.
REQ-017 On reset deassertion, the block SHALL start in HUNT. Reset mid-byte or mid-lock SHALL discard the partial byte with no lock_lost pulse.

Structure
REQ-018 The package phy_rx_pkg SHALL hold the COMMA default constant and the state encoding (HUNT/CHECK/LOCKED) shared with the RX datapath.
REQ-019 The shift register plus comma comparator SHALL be the sub-module phy_rx_comma_det (outputs shift_q and comma_hit). The FSM and counters SHALL stay in the top module.

Verification
REQ-020 Lock: send 5 BC bytes at arbitrary bit offset 3, then 8'h5A.
- locked rises after the 4th aligned BC.
- The 5th BC strobes with valid_out=0.
- 8'h5A strobes with valid_out=1.
REQ-021 False start: send BC, BC, then 8'h11 aligned in CHECK → return to HUNT, locked stays 0, lock_lost stays 0.
REQ-022 Loss of lock: after lock, send 64 non-comma bytes 8'h01..8'h40 → 64 strobes, lock_lost pulses once with the 64th strobe, state=HUNT.
REQ-023 Misaligned comma: while locked, inject the pattern 8'hBC straddling a boundary inside payload 8'h0B,8'hC0 → no realignment, bytes 8'h0B,8'hC0 emitted valid.
REQ-024 Overrides: sync_en low for 1 cycle while locked → lock_lost pulse, HUNT. reset asserted mid-byte → all outputs 0 immediately; relock after 4 BC.
